// File: rtl/commit_monitor_pkg.sv
// Shared types and defaults for the commit monitor: commit entry layout,
// monitor FSM states and the default end-of-test PC.
package commit_monitor_pkg;

    localparam int PC_WIDTH = 32;
    localparam int INSTR_W  = 32;
    localparam int unsigned COMMIT_STOP_PC = 32'h58;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } commit_entry_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_DONE = 2'd1,
        REPORT    = 2'd2
    } monitor_state_e;

endpackage

// File: rtl/commit_monitor_fifo.sv
// Commit FIFO: up to NUM_PORTS writes per cycle in lane order, one read per cycle.
// The caller guarantees push_cnt_i never exceeds free space and pop_i only when non-empty.
module commit_fifo #(
    parameter int W         = 64,
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 16,
    localparam int LCW      = $clog2(NUM_PORTS + 1),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0][W-1:0]   push_data_i,
    input  logic [LCW-1:0]                push_cnt_i,
    input  logic                          pop_i,
    output logic [W-1:0]                  head_o,
    output logic [CW-1:0]                 count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Storage has no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (LCW'(i) < push_cnt_i) begin
                mem[wr_ptr + AW'(i)] <= push_data_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt_i);
            rd_ptr <= rd_ptr + AW'(pop_i);
            count  <= count + CW'(push_cnt_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/commit_monitor.sv
// Multi-lane retirement checker: buffers commits, compares them in order against the
// golden stream, keeps counters and runs the finish -> done -> report handshake.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = PC_WIDTH,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] STOP_PC = ADDR_WIDTH'(COMMIT_STOP_PC)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             commit_valid_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  commit_pc_i,
    input  logic [NUM_PORTS*INSTR_WIDTH-1:0] commit_instr_i,
    // Expected stream handshake: an entry transfers on any cycle where exp_valid_i and
    // exp_ready_o are both high; exp_ready_o may depend combinationally on exp_valid_i.
    input  logic                             exp_valid_i,
    input  logic [ADDR_WIDTH-1:0]            exp_pc_i,
    input  logic [INSTR_WIDTH-1:0]           exp_instr_i,
    output logic                             exp_ready_o,
    input  logic                             done_i,
    output logic                             finish_o,
    output logic                             mismatch_o,
    output logic [ADDR_WIDTH-1:0]            mismatch_pc_o,
    output logic [INSTR_WIDTH-1:0]           mismatch_instr_o,
    output logic [CNT_WIDTH-1:0]             error_count_o,
    output logic [CNT_WIDTH-1:0]             instr_count_o,
    output logic [CNT_WIDTH-1:0]             cycle_count_o,
    output logic                             overflow_o,
    output logic                             protocol_err_o,
    output logic                             report_valid_o,
    output monitor_state_e                   state_o
);

    localparam int EW  = ADDR_WIDTH + INSTR_WIDTH;
    localparam int LCW = $clog2(NUM_PORTS + 1);
    localparam int CW  = $clog2(DEPTH) + 1;

    monitor_state_e state_q, state_d;

    logic [NUM_PORTS-1:0][EW-1:0] lane_data;
    logic [LCW-1:0]               contig;
    logic                         gap_seen;
    logic                         lane_gap_err;
    logic [CW-1:0]                fifo_count;
    logic [CW-1:0]                free_slots;
    logic [LCW-1:0]               push_cnt;
    logic                         in_run;
    logic                         drop;
    logic                         pop;
    logic                         differ;
    logic [EW-1:0]                head;
    logic [ADDR_WIDTH-1:0]        head_pc;
    logic [INSTR_WIDTH-1:0]       head_instr;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        assign lane_data[g] = {commit_pc_i[g*ADDR_WIDTH +: ADDR_WIDTH],
                               commit_instr_i[g*INSTR_WIDTH +: INSTR_WIDTH]};
    end

    // Count valid lanes contiguous from lane 0; any valid lane past a gap is a protocol error.
    always_comb begin
        contig       = '0;
        gap_seen     = 1'b0;
        lane_gap_err = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!commit_valid_i[i]) begin
                gap_seen = 1'b1;
            end else if (gap_seen) begin
                lane_gap_err = 1'b1;
            end else begin
                contig = contig + LCW'(1);
            end
        end
    end

    assign in_run     = (state_q == RUN);
    assign free_slots = CW'(DEPTH) - fifo_count;
    assign drop       = in_run && (CW'(contig) > free_slots);
    assign push_cnt   = !in_run ? '0 : (drop ? free_slots[LCW-1:0] : contig);

    assign exp_ready_o = in_run && (fifo_count != '0) && exp_valid_i;
    assign pop         = exp_ready_o;
    assign head_pc     = head[EW-1 -: ADDR_WIDTH];
    assign head_instr  = head[INSTR_WIDTH-1:0];
    assign differ      = (head_pc != exp_pc_i) || (head_instr != exp_instr_i);

    commit_fifo #(
        .W         (EW),
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_data_i (lane_data),
        .push_cnt_i  (push_cnt),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (pop && head_pc == STOP_PC) state_d = WAIT_DONE;
            WAIT_DONE: if (done_i) state_d = REPORT;
            REPORT:    state_d = REPORT;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= RUN;
            mismatch_o       <= 1'b0;
            mismatch_pc_o    <= '0;
            mismatch_instr_o <= '0;
            error_count_o    <= '0;
            instr_count_o    <= '0;
            cycle_count_o    <= '0;
            overflow_o       <= 1'b0;
            protocol_err_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mismatch_o <= pop && differ;
            if (state_q != REPORT && cycle_count_o != '1) begin
                cycle_count_o <= cycle_count_o + CNT_WIDTH'(1);
            end
            if (in_run && lane_gap_err) protocol_err_o <= 1'b1;
            if (drop) overflow_o <= 1'b1;
            if (pop) begin
                if (instr_count_o != '1) instr_count_o <= instr_count_o + CNT_WIDTH'(1);
                if (differ) begin
                    mismatch_pc_o    <= head_pc;
                    mismatch_instr_o <= head_instr;
                    if (error_count_o != '1) error_count_o <= error_count_o + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign finish_o       = (state_q != RUN);
    assign report_valid_o = (state_q == REPORT);
    assign state_o        = state_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of the monitor.
module tb_commit_monitor;
    import commit_monitor_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int CW    = 32;
    localparam logic [AW-1:0] STOP = 32'h58;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    cv;
    logic [AW-1:0]    cpc  [NP];
    logic [IW-1:0]    cins [NP];
    logic             exp_valid;
    logic [AW-1:0]    exp_pc;
    logic [IW-1:0]    exp_instr;
    logic             done;

    logic [NP*AW-1:0] commit_pc;
    logic [NP*IW-1:0] commit_instr;
    logic             exp_ready, finish, mismatch, overflow, protocol_err, report_valid;
    logic [AW-1:0]    mismatch_pc;
    logic [IW-1:0]    mismatch_instr;
    logic [CW-1:0]    error_count, instr_count, cycle_count;
    monitor_state_e   state;

    assign commit_pc    = {cpc[1], cpc[0]};
    assign commit_instr = {cins[1], cins[0]};

    commit_monitor #(
        .NUM_PORTS(NP), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW),
        .STOP_PC(STOP)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .commit_valid_i(cv), .commit_pc_i(commit_pc), .commit_instr_i(commit_instr),
        .exp_valid_i(exp_valid), .exp_pc_i(exp_pc), .exp_instr_i(exp_instr),
        .exp_ready_o(exp_ready), .done_i(done), .finish_o(finish),
        .mismatch_o(mismatch), .mismatch_pc_o(mismatch_pc), .mismatch_instr_o(mismatch_instr),
        .error_count_o(error_count), .instr_count_o(instr_count), .cycle_count_o(cycle_count),
        .overflow_o(overflow), .protocol_err_o(protocol_err), .report_valid_o(report_valid),
        .state_o(state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model
    commit_entry_t  mq[$];
    monitor_state_e m_state;
    logic           m_mism, m_ovf, m_perr;
    logic [AW-1:0]  m_mpc;
    logic [IW-1:0]  m_minstr;
    logic [CW-1:0]  m_err, m_instr, m_cycles;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1;
    endfunction

    function automatic logic [IW-1:0] ins_of(input logic [AW-1:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = RUN; m_mism = 0; m_ovf = 0; m_perr = 0;
        m_mpc = '0; m_minstr = '0; m_err = '0; m_instr = '0; m_cycles = '0;
    endtask

    task automatic model_step();
        int n, sz, take;
        commit_entry_t e, ne;
        m_mism = 1'b0;
        if (m_state == REPORT) return;
        m_cycles = sat_inc(m_cycles);
        if (m_state == WAIT_DONE) begin
            if (done) m_state = REPORT;
            return;
        end
        n = 0;
        while (n < NP && cv[n]) n++;
        if ((cv >> n) != 0) m_perr = 1'b1;
        sz = mq.size();
        if (sz > 0 && exp_valid) begin
            e = mq.pop_front();
            m_instr = sat_inc(m_instr);
            if (e.pc !== exp_pc || e.instr !== exp_instr) begin
                m_mism = 1'b1; m_mpc = e.pc; m_minstr = e.instr; m_err = sat_inc(m_err);
            end
            if (e.pc == STOP) m_state = WAIT_DONE;
        end
        take = (n < DEPTH - sz) ? n : DEPTH - sz;
        if (n > take) m_ovf = 1'b1;
        for (int i = 0; i < take; i++) begin
            ne.pc = cpc[i]; ne.instr = cins[i];
            mq.push_back(ne);
        end
    endtask

    task automatic check_outputs();
        cmp("state", 64'(state), 64'(m_state));
        cmp("finish", finish, m_state != RUN);
        cmp("report_valid", report_valid, m_state == REPORT);
        cmp("mismatch", mismatch, m_mism);
        cmp("mismatch_pc", mismatch_pc, m_mpc);
        cmp("mismatch_instr", mismatch_instr, m_minstr);
        cmp("error_count", error_count, m_err);
        cmp("instr_count", instr_count, m_instr);
        cmp("cycle_count", cycle_count, m_cycles);
        cmp("overflow", overflow, m_ovf);
        cmp("protocol_err", protocol_err, m_perr);
    endtask

    // Inputs are set at the falling edge; ready is combinational, the rest is post-edge.
    task automatic tick();
        #1;
        cmp("exp_ready", exp_ready, (m_state == RUN) && (mq.size() > 0) && exp_valid);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cv = '0; exp_valid = 1'b0; done = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_lanes(input logic [NP-1:0] v, input logic [AW-1:0] pc0);
        cv = v;
        for (int i = 0; i < NP; i++) begin
            cpc[i]  = pc0 + AW'(4 * i);
            cins[i] = ins_of(cpc[i]);
        end
    endtask

    task automatic set_exp(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] ins);
        exp_valid = v; exp_pc = pc; exp_instr = ins;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] next_pc;
        int lo_phase;
        cv = '0; done = 1'b0;
        set_lanes(2'b00, '0);
        set_exp(1'b0, '0, '0);
        @(negedge clk);

        // Two lanes in one cycle, popped on two consecutive cycles.
        do_reset();
        set_lanes(2'b11, 32'h0); tick();
        cv = '0;
        set_exp(1'b1, 32'h0, ins_of(32'h0)); tick();
        set_exp(1'b1, 32'h4, ins_of(32'h4)); tick();
        set_exp(1'b0, '0, '0); tick();
        cmp("lit_instr_count_2", instr_count, 2);
        cmp("lit_error_count_0", error_count, 0);

        // Instruction mismatch at PC 0x8.
        do_reset();
        cv = 2'b01; cpc[0] = 32'h8; cins[0] = 32'h00b00093; tick();
        cv = '0;
        set_exp(1'b1, 32'h8, 32'h00a00093); tick();
        cmp("lit_mismatch_pulse", mismatch, 1);
        cmp("lit_mismatch_pc", mismatch_pc, 32'h8);
        cmp("lit_mismatch_instr", mismatch_instr, 32'h00b00093);
        cmp("lit_error_count_1", error_count, 1);
        set_exp(1'b0, '0, '0); tick();
        cmp("lit_mismatch_clear", mismatch, 0);

        // Fill past capacity with the expected stream stalled, then drain in order.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            set_lanes(2'b11, AW'(8 * k)); tick();
        end
        cv = '0;
        cmp("lit_overflow", overflow, 1);
        for (int k = 0; k < 16; k++) begin
            set_exp(1'b1, AW'(4 * k), ins_of(AW'(4 * k))); tick();
        end
        set_exp(1'b1, 32'h40, ins_of(32'h40)); tick();
        cmp("lit_drain_count_16", instr_count, 16);
        cmp("lit_drain_errors_0", error_count, 0);

        // Lane 1 without lane 0: protocol error and nothing pushed.
        do_reset();
        set_lanes(2'b10, 32'h20);
        set_exp(1'b1, 32'h24, ins_of(32'h24)); tick();
        cmp("lit_protocol_err", protocol_err, 1);
        cv = '0; tick();
        cmp("lit_protocol_no_push", instr_count, 0);

        // Randomized traffic.
        do_reset();
        next_pc = 32'h1000;
        for (int c = 0; c < 1500; c++) begin
            int r;
            lo_phase = ((c / 200) % 2 == 0) ? 1 : 0;
            r = $urandom_range(0, 15);
            if (r < 1)      set_lanes(2'b10, next_pc);
            else if (r < 5) set_lanes(2'b00, next_pc);
            else if (r < 9) set_lanes(2'b01, next_pc);
            else            set_lanes(2'b11, next_pc);
            next_pc = next_pc + 8;
            for (int i = 0; i < NP; i++) cins[i] = $urandom();
            exp_valid = lo_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (mq.size() > 0) begin
                exp_pc = mq[0].pc; exp_instr = mq[0].instr;
                r = $urandom_range(0, 15);
                if (r == 0) exp_pc = exp_pc ^ 32'h4;
                else if (r == 1) exp_instr = exp_instr ^ (32'h1 << $urandom_range(0, 31));
            end else begin
                exp_pc = $urandom(); exp_instr = $urandom();
            end
            done = $urandom_range(0, 1);
            tick();
        end

        // End-of-test handshake, then frozen report.
        do_reset();
        set_lanes(2'b11, STOP); tick();
        cv = '0;
        set_exp(1'b1, STOP, ins_of(STOP)); tick();
        cmp("lit_finish_after_stop", finish, 1);
        for (int k = 0; k < 5; k++) begin
            set_lanes(2'b11, 32'h200 + AW'(8 * k));
            set_exp(1'b1, 32'h5c, ins_of(32'h5c));
            tick();
        end
        done = 1'b1; tick();
        cmp("lit_report_valid", report_valid, 1);
        cmp("lit_report_cycles", cycle_count, 8);
        for (int k = 0; k < 5; k++) begin
            set_lanes(2'b11, 32'h300 + AW'(8 * k)); tick();
        end
        cmp("lit_cycles_frozen", cycle_count, 8);
        cmp("lit_report_instr_count", instr_count, 1);

        // Reset asserted while waiting for done; the entry left behind must be gone.
        do_reset();
        set_lanes(2'b11, STOP); tick();
        cv = '0;
        set_exp(1'b1, STOP, ins_of(STOP)); tick();
        set_exp(1'b1, 32'h5c, ins_of(32'h5c)); tick();
        cmp("lit_in_wait_done", 64'(state), 64'(WAIT_DONE));
        do_reset();
        cmp("lit_reset_finish_low", finish, 0);
        set_exp(1'b1, 32'h5c, ins_of(32'h5c)); tick();
        cmp("lit_reset_fifo_empty", instr_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
